// File: rtl/csi2_pkt_gen.sv
// CSI-2 transmit packet generator: wraps AXI4-Stream line payload into
// FS / long packet (header, payload, CRC-16 footer) / FE 32-bit words.
module csi2_pkt_gen #(
  parameter logic [5:0] DATA_TYPE = 6'h2B,
  parameter logic [1:0] VC        = 2'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [15:0] word_count_i,
  input  logic [15:0] lines_i,
  input  logic [31:0] pkt_i_tdata,
  input  logic        pkt_i_tvalid,
  output logic        pkt_i_tready,
  input  logic        pkt_i_tuser,
  input  logic        pkt_i_tlast,
  output logic [31:0] pkt_o_tdata,
  output logic        pkt_o_tvalid,
  input  logic        pkt_o_tready,
  output logic [3:0]  pkt_o_tstrb,
  output logic        pkt_o_tlast,
  output logic        length_err_o
);

  typedef enum logic [2:0] {IDLE, FS, HDR, PAYLOAD, CRC, FE} state_t;

  state_t      state;
  logic [15:0] frame_num, lines, line_cnt, wc, byte_cnt, crc;
  logic        pad, drain;
  logic        adv, take_data, data_fire, payload_last, more_lines;
  logic [31:0] data_word;

  function automatic logic [7:0] ecc(input logic [23:0] h);
    logic [5:0] p;
    p[0] = ^(h & 24'hF12CB7);
    p[1] = ^(h & 24'hF2555B);
    p[2] = ^(h & 24'h749A6D);
    p[3] = ^(h & 24'hB8E38E);
    p[4] = ^(h & 24'hDF03F0);
    p[5] = ^(h & 24'hEFFC00);
    return {2'b00, p};
  endfunction

  function automatic logic [31:0] pkt_hdr(input logic [7:0] di, input logic [15:0] field);
    return {ecc({field, di}), field, di};
  endfunction

  // Reflected CCITT, bits taken in wire order: byte0 first, LSB first.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 32; i++)
      r = (r[0] ^ w[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  // State names the word currently held in the output register; each
  // transition loads the next word, so the stream runs without bubbles.
  assign adv          = !pkt_o_tvalid || pkt_o_tready;
  assign take_data    = (state == HDR && wc != '0) || (state == PAYLOAD && byte_cnt != wc);
  assign payload_last = (16'(byte_cnt + 16'd4) == wc);
  assign more_lines   = ({1'b0, line_cnt} + 17'd1) < {1'b0, lines};
  assign data_fire    = take_data && adv && (pad || pkt_i_tvalid);
  assign data_word    = pad ? '0 : pkt_i_tdata;

  always_comb begin
    pkt_i_tready = 1'b0;
    if (rst_n_i) begin
      case (state)
        IDLE:    pkt_i_tready = pkt_i_tvalid && !pkt_i_tuser;
        CRC:     pkt_i_tready = drain;
        default: pkt_i_tready = take_data && !pad && adv;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      pkt_o_tvalid <= 1'b0;
      pkt_o_tdata  <= '0;
      pkt_o_tstrb  <= '0;
      pkt_o_tlast  <= 1'b0;
      length_err_o <= 1'b0;
      frame_num    <= 16'h0001;
      lines        <= '0;
      line_cnt     <= '0;
      wc           <= '0;
      byte_cnt     <= '0;
      crc          <= '1;
      pad          <= 1'b0;
      drain        <= 1'b0;
    end else begin
      length_err_o <= 1'b0;
      if (adv) pkt_o_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (adv && enable_i && pkt_i_tvalid && pkt_i_tuser) begin
            pkt_o_tvalid <= 1'b1;
            pkt_o_tdata  <= pkt_hdr({VC, 6'h00}, frame_num);
            pkt_o_tstrb  <= 4'hF;
            pkt_o_tlast  <= 1'b1;
            lines        <= lines_i;
            line_cnt     <= '0;
            state        <= FS;
          end
        end
        FS: begin
          if (adv) begin
            pkt_o_tvalid <= 1'b1;
            pkt_o_tdata  <= pkt_hdr({VC, DATA_TYPE}, word_count_i);
            pkt_o_tstrb  <= 4'hF;
            pkt_o_tlast  <= 1'b0;
            wc           <= word_count_i;
            byte_cnt     <= '0;
            crc          <= '1;
            state        <= HDR;
          end
        end
        HDR, PAYLOAD: begin
          if (take_data) begin
            if (data_fire) begin
              pkt_o_tvalid <= 1'b1;
              pkt_o_tdata  <= data_word;
              pkt_o_tstrb  <= 4'hF;
              pkt_o_tlast  <= 1'b0;
              crc          <= crc_upd(crc, data_word);
              byte_cnt     <= 16'(byte_cnt + 16'd4);
              state        <= PAYLOAD;
              if (payload_last) begin
                pad <= 1'b0;
                if (!pad && !pkt_i_tlast) begin
                  length_err_o <= 1'b1;
                  drain        <= 1'b1;
                end
              end else if (!pad && pkt_i_tlast) begin
                length_err_o <= 1'b1;
                pad          <= 1'b1;
              end
            end
          end else if (adv) begin
            pkt_o_tvalid <= 1'b1;
            pkt_o_tdata  <= {16'h0000, crc};
            pkt_o_tstrb  <= 4'h3;
            pkt_o_tlast  <= 1'b1;
            state        <= CRC;
          end
        end
        CRC: begin
          if (drain && pkt_i_tvalid && pkt_i_tlast) drain <= 1'b0;
          if (adv) begin
            if (more_lines) begin
              if (!drain) begin
                pkt_o_tvalid <= 1'b1;
                pkt_o_tdata  <= pkt_hdr({VC, DATA_TYPE}, word_count_i);
                pkt_o_tstrb  <= 4'hF;
                pkt_o_tlast  <= 1'b0;
                wc           <= word_count_i;
                byte_cnt     <= '0;
                crc          <= '1;
                line_cnt     <= 16'(line_cnt + 16'd1);
                state        <= HDR;
              end
            end else begin
              pkt_o_tvalid <= 1'b1;
              pkt_o_tdata  <= pkt_hdr({VC, 6'h01}, frame_num);
              pkt_o_tstrb  <= 4'hF;
              pkt_o_tlast  <= 1'b1;
              drain        <= 1'b0;
              state        <= FE;
            end
          end
        end
        FE: begin
          if (adv) begin
            frame_num <= (frame_num == 16'hFFFF) ? 16'h0001 : 16'(frame_num + 16'd1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
